// File: rtl/pipeline_pkg.sv
// Shared types for the EX/MEM/WB pipeline register bank.
// Defines the writeback-source encoding and the per-stage payload struct.
package pipeline_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;

  typedef enum logic [1:0] {
    ALU  = 2'b00,
    LOAD = 2'b01,
    PC4  = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic             valid;
    logic [AddrW-1:0] rd_addr;
    logic             rd_wren;
    wb_sel_e          wb_sel;
    logic             mem_req;
    logic [DataW-1:0] alu_result;
    logic [DataW-1:0] pc4;
  } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding a stage_t payload.
// Hold freezes the stage; flush loads an all-zero bubble.
module pipe_stage_reg
  import pipeline_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_hold,
  input  logic   i_flush,
  input  stage_t i_d,
  output stage_t o_q
);

  stage_t q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q <= '0;
    end else if (i_hold) begin
      q <= q;
    end else if (i_flush) begin
      q <= '0;
    end else begin
      q <= i_d;
    end
  end

  assign o_q = q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with LSU hold, flush, forwarding
// data selection and load-use hazard detection.
module ex_mem_wb_pipe
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = DataW,  // must equal DataW; stage_t is sized by the package
  parameter int unsigned AW = AddrW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ex_valid,
  input  logic [AW-1:0] i_ex_rd_addr,
  input  logic          i_ex_rd_wren,
  input  logic [1:0]    i_ex_wb_sel,
  input  logic          i_ex_mem_req,
  input  logic [DW-1:0] i_ex_alu_result,
  input  logic [DW-1:0] i_ex_pc4,
  input  logic          i_flush_ex,
  input  logic [AW-1:0] i_id_rs1_addr,
  input  logic [AW-1:0] i_id_rs2_addr,
  input  logic          i_lsu_ready,
  input  logic [DW-1:0] i_lsu_rdata,
  output logic [AW-1:0] o_mem_rd_addr,
  output logic [AW-1:0] o_wb_rd_addr,
  output logic          o_rd_wren_mem,
  output logic          o_rd_wren_wb,
  output logic [DW-1:0] o_mem_fwd_data,
  output logic [DW-1:0] o_wb_data,
  output logic          o_load_use_stall,
  output logic          o_pipe_hold
);

  stage_t          ex_d;
  stage_t          mem_q;
  stage_t          wb_q;
  logic [DW-1:0]   wb_rdata_q;
  logic            hold;
  logic            unused_wb_mem_req;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = i_ex_valid;
    ex_d.rd_addr    = i_ex_rd_addr;
    ex_d.rd_wren    = i_ex_rd_wren;
    ex_d.wb_sel     = wb_sel_e'(i_ex_wb_sel);
    ex_d.mem_req    = i_ex_mem_req;
    ex_d.alu_result = i_ex_alu_result;
    ex_d.pc4        = i_ex_pc4;
  end

  assign hold = mem_q.valid & mem_q.mem_req & ~i_lsu_ready;

  pipe_stage_reg u_ex_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hold  (hold),
    .i_flush (i_flush_ex),
    .i_d     (ex_d),
    .o_q     (mem_q)
  );

  pipe_stage_reg u_mem_wb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hold  (hold),
    .i_flush (1'b0),
    .i_d     (mem_q),
    .o_q     (wb_q)
  );

  // Any non-hold edge with a valid access is the completing edge, so rdata is taken there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_rdata_q <= '0;
    end else if (!hold) begin
      wb_rdata_q <= i_lsu_rdata;
    end
  end

  always_comb begin
    o_mem_fwd_data = mem_q.alu_result;
    if (mem_q.wb_sel == PC4) begin
      o_mem_fwd_data = mem_q.pc4;
    end
  end

  always_comb begin
    o_wb_data = wb_q.alu_result;
    case (wb_q.wb_sel)
      LOAD:    o_wb_data = wb_rdata_q;
      PC4:     o_wb_data = wb_q.pc4;
      default: o_wb_data = wb_q.alu_result;
    endcase
  end

  assign o_mem_rd_addr = mem_q.rd_addr;
  assign o_wb_rd_addr  = wb_q.rd_addr;
  assign o_rd_wren_mem = mem_q.valid & mem_q.rd_wren;
  assign o_rd_wren_wb  = wb_q.valid & wb_q.rd_wren;
  assign o_pipe_hold   = hold;

  assign o_load_use_stall = i_ex_valid & i_ex_rd_wren & (i_ex_wb_sel == LOAD)
                          & (i_ex_rd_addr != '0)
                          & ((i_ex_rd_addr == i_id_rs1_addr) | (i_ex_rd_addr == i_id_rs2_addr));

  assign unused_wb_mem_req = wb_q.mem_req;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: a vector table for single-cycle behaviour
// plus hand sequences for LSU hold and asynchronous reset mid-hold.
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_rd_wren, ex_mem_req, flush_ex, lsu_ready;
  logic [4:0]  ex_rd_addr, rs1, rs2;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu, ex_pc4, lsu_rdata;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        rd_wren_mem, rd_wren_wb, load_use_stall, pipe_hold;
  logic [31:0] mem_fwd_data, wb_data;

  int n_vec = 0;
  int n_bad = 0;

  ex_mem_wb_pipe #(.DW(32), .AW(5)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ex_valid       (ex_valid),
    .i_ex_rd_addr     (ex_rd_addr),
    .i_ex_rd_wren     (ex_rd_wren),
    .i_ex_wb_sel      (ex_wb_sel),
    .i_ex_mem_req     (ex_mem_req),
    .i_ex_alu_result  (ex_alu),
    .i_ex_pc4         (ex_pc4),
    .i_flush_ex       (flush_ex),
    .i_id_rs1_addr    (rs1),
    .i_id_rs2_addr    (rs2),
    .i_lsu_ready      (lsu_ready),
    .i_lsu_rdata      (lsu_rdata),
    .o_mem_rd_addr    (mem_rd_addr),
    .o_wb_rd_addr     (wb_rd_addr),
    .o_rd_wren_mem    (rd_wren_mem),
    .o_rd_wren_wb     (rd_wren_wb),
    .o_mem_fwd_data   (mem_fwd_data),
    .o_wb_data        (wb_data),
    .o_load_use_stall (load_use_stall),
    .o_pipe_hold      (pipe_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, wren;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        mreq;
    logic [31:0] alu, pc4;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic        rdy;
    logic [31:0] rdata;
    logic [4:0]  e_mrd;
    logic        e_wmem;
    logic [31:0] e_fwd;
    logic [4:0]  e_wrd;
    logic        e_wwb;
    logic [31:0] e_wbd;
    logic        e_stall, e_hold;
    logic        mem_dc, wb_dc;  // skip tag/data of a bubbled stage
  } vec_t;

  vec_t vec [11];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd_wren = 0; ex_rd_addr = 0; ex_wb_sel = 2'b00; ex_mem_req = 0;
    ex_alu = 0; ex_pc4 = 0; flush_ex = 0; rs1 = 0; rs2 = 0; lsu_ready = 1; lsu_rdata = 0;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic [1:0] sel, input logic mreq,
                        input logic [31:0] alu);
    ex_valid = 1; ex_rd_wren = 1; ex_rd_addr = rd; ex_wb_sel = sel; ex_mem_req = mreq;
    ex_alu = alu;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, " mem_rd"}, 32'(mem_rd_addr), 0);
    cmp({tag, " wb_rd"}, 32'(wb_rd_addr), 0);
    cmp({tag, " wren_mem"}, 32'(rd_wren_mem), 0);
    cmp({tag, " wren_wb"}, 32'(rd_wren_wb), 0);
    cmp({tag, " mem_fwd"}, mem_fwd_data, 0);
    cmp({tag, " wb_data"}, wb_data, 0);
    cmp({tag, " stall"}, 32'(load_use_stall), 0);
    cmp({tag, " hold"}, 32'(pipe_hold), 0);
  endtask

  initial begin
    //          vld wr rd sel mrq alu           pc4          fl rs1 rs2 rdy rdata
    //          e_mrd e_wmem e_fwd  e_wrd e_wwb e_wbd  stall hold mdc wdc
    vec[0]  = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 0};
    vec[1]  = '{1, 1, 5, 0, 0, 32'h1234,   32'h100,   0, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h0,
                5, 1, 32'h1234,   0, 0, 32'h0,      0, 0, 0, 0};
    vec[3]  = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      5, 1, 32'h1234,   0, 0, 0, 0};
    vec[4]  = '{1, 1, 7, 1, 1, 32'h2000,   32'h0,     0, 3, 7, 1, 32'h0,
                0, 0, 32'h0,      0, 0, 32'h0,      1, 0, 0, 0};
    vec[5]  = '{1, 1, 0, 1, 1, 32'h3000,   32'h0,     0, 0, 0, 1, 32'hCAFEF00D,
                7, 1, 32'h2000,   0, 0, 32'h0,      0, 0, 0, 0};
    vec[6]  = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h11112222,
                0, 1, 32'h3000,   7, 1, 32'hCAFEF00D, 0, 0, 0, 0};
    vec[7]  = '{1, 1, 1, 2, 0, 32'h500,    32'h104,   1, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      0, 1, 32'h11112222, 0, 0, 0, 0};
    vec[8]  = '{1, 1, 1, 2, 0, 32'h500,    32'h104,   0, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 1, 0};
    vec[9]  = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h0,
                1, 1, 32'h104,    0, 0, 32'h0,      0, 0, 0, 1};
    vec[10] = '{0, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0, 0, 1, 32'h0,
                0, 0, 32'h0,      1, 1, 32'h104,    0, 0, 0, 0};

    idle_inputs();
    rst_n = 0;
    #2;
    check_all_zero("reset");
    #10 rst_n = 1;
    tick();

    for (int i = 0; i < 11; i++) begin
      ex_valid = vec[i].valid; ex_rd_wren = vec[i].wren; ex_rd_addr = vec[i].rd;
      ex_wb_sel = vec[i].sel; ex_mem_req = vec[i].mreq; ex_alu = vec[i].alu;
      ex_pc4 = vec[i].pc4; flush_ex = vec[i].flush; rs1 = vec[i].rs1; rs2 = vec[i].rs2;
      lsu_ready = vec[i].rdy; lsu_rdata = vec[i].rdata;
      #3;
      if (!vec[i].mem_dc) begin
        cmp($sformatf("v%0d mem_rd", i), 32'(mem_rd_addr), 32'(vec[i].e_mrd));
        cmp($sformatf("v%0d mem_fwd", i), mem_fwd_data, vec[i].e_fwd);
      end
      if (!vec[i].wb_dc) begin
        cmp($sformatf("v%0d wb_rd", i), 32'(wb_rd_addr), 32'(vec[i].e_wrd));
        cmp($sformatf("v%0d wb_data", i), wb_data, vec[i].e_wbd);
      end
      cmp($sformatf("v%0d wren_mem", i), 32'(rd_wren_mem), 32'(vec[i].e_wmem));
      cmp($sformatf("v%0d wren_wb", i), 32'(rd_wren_wb), 32'(vec[i].e_wwb));
      cmp($sformatf("v%0d stall", i), 32'(load_use_stall), 32'(vec[i].e_stall));
      cmp($sformatf("v%0d hold", i), 32'(pipe_hold), 32'(vec[i].e_hold));
      tick();
    end

    // LSU hold: load stalls 3 cycles while an older ALU op sits in MEM/WB.
    idle_inputs();
    set_ex(5'd3, 2'b00, 1'b0, 32'h77);
    tick();
    idle_inputs();
    set_ex(5'd9, 2'b01, 1'b1, 32'h40);
    lsu_ready = 0;
    #3;
    cmp("pre-hold hold", 32'(pipe_hold), 0);
    cmp("pre-hold mem_rd", 32'(mem_rd_addr), 3);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      set_ex(5'd12, 2'b00, 1'b0, 32'h99);
      lsu_ready = 0;
      #3;
      cmp($sformatf("hold%0d hold", k), 32'(pipe_hold), 1);
      cmp($sformatf("hold%0d mem_rd", k), 32'(mem_rd_addr), 9);
      cmp($sformatf("hold%0d mem_fwd", k), mem_fwd_data, 32'h40);
      cmp($sformatf("hold%0d wb_rd", k), 32'(wb_rd_addr), 3);
      cmp($sformatf("hold%0d wb_data", k), wb_data, 32'h77);
      tick();
    end
    idle_inputs();
    lsu_rdata = 32'hDEADBEEF;
    #3;
    cmp("release hold", 32'(pipe_hold), 0);
    cmp("release mem_rd", 32'(mem_rd_addr), 9);
    tick();
    idle_inputs();
    set_ex(5'd4, 2'b00, 1'b0, 32'hAB);
    #3;
    cmp("load wb_data", wb_data, 32'hDEADBEEF);
    cmp("load wb_rd", 32'(wb_rd_addr), 9);
    cmp("load wren_wb", 32'(rd_wren_wb), 1);
    cmp("load hold", 32'(pipe_hold), 0);
    tick();

    // Asynchronous reset in the middle of a hold.
    idle_inputs();
    set_ex(5'd10, 2'b01, 1'b1, 32'h80);
    tick();
    idle_inputs();
    lsu_ready = 0;
    #2;
    cmp("pre-rst hold", 32'(pipe_hold), 1);
    cmp("pre-rst wb_data", wb_data, 32'hAB);
    rst_n = 0;
    #1;
    check_all_zero("async rst");
    @(posedge clk);
    #2 rst_n = 1;
    idle_inputs();
    tick();
    check_all_zero("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
